id_ex_stage: RTL and testbench

- ID/EX pipeline register for the 16-bit core. Captures decoded operands and control at the end of decode, then presents them to the execute-stage units: the ALU, the RED reducer, PADDSB and the shifter.
- Resolves RAW hazards with an EX/MEM and MEM/WB forwarding mux on its register outputs, so the reducer and ALU always see current rs/rt values.
- Supports stall (hold) and flush (bubble) from the hazard/branch logic.

---
 rtl/cpu_pkg.sv | 33 +++
 rtl/id_ex_stage_fwd_mux.sv | 39 +++
 rtl/id_ex_stage.sv | 125 ++++++++++++
 tb/tb_id_ex_stage.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit core: opcode encodings, forwarding
// select encodings and default datapath widths.
package cpu_pkg;

  localparam int DW_DEF = 16;
  localparam int RW_DEF = 4;

  typedef enum logic [3:0] {
    OP_ADD    = 4'b0000,
    OP_SUB    = 4'b0001,
    OP_XOR    = 4'b0010,
    OP_RED    = 4'b0011,
    OP_SLL    = 4'b0100,
    OP_SRA    = 4'b0101,
    OP_ROR    = 4'b0110,
    OP_PADDSB = 4'b0111,
    OP_LW     = 4'b1000,
    OP_SW     = 4'b1001,
    OP_LLB    = 4'b1010,
    OP_LHB    = 4'b1011,
    OP_B      = 4'b1100,
    OP_BR     = 4'b1101,
    OP_PCS    = 4'b1110,
    OP_HLT    = 4'b1111
  } opcode_e;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// Single-operand RAW forwarding mux: EX/MEM beats MEM/WB beats the
// registered regfile value; R0 is never forwarded.
module fwd_mux
  import cpu_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int RW = RW_DEF
) (
  input  logic [RW-1:0] src_addr,
  input  logic [DW-1:0] reg_data,
  input  logic          exmem_regwrite,
  input  logic [RW-1:0] exmem_rd,
  input  logic [DW-1:0] exmem_result,
  input  logic          memwb_regwrite,
  input  logic [RW-1:0] memwb_rd,
  input  logic [DW-1:0] memwb_result,
  output logic [DW-1:0] val,
  output logic [1:0]    sel
);

  logic hit_mem;
  logic hit_wb;

  assign hit_mem = exmem_regwrite && (exmem_rd != '0) && (exmem_rd == src_addr);
  assign hit_wb  = memwb_regwrite && (memwb_rd != '0) && (memwb_rd == src_addr);

  always_comb begin
    val = reg_data;
    sel = FWD_REG;
    if (hit_mem) begin
      val = exmem_result;
      sel = FWD_MEM;
    end else if (hit_wb) begin
      val = memwb_result;
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with stall/flush control and combinational
// EX/MEM and MEM/WB forwarding on the rs/rt operand outputs.
module id_ex_stage
  import cpu_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int RW = RW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall,
  input  logic          flush,
  input  logic          id_valid,
  input  logic [3:0]    id_opcode,
  input  logic [RW-1:0] id_rs_addr,
  input  logic [RW-1:0] id_rt_addr,
  input  logic [RW-1:0] id_rd_addr,
  input  logic [DW-1:0] id_rs_data,
  input  logic [DW-1:0] id_rt_data,
  input  logic [DW-1:0] id_imm,
  input  logic          id_regwrite,
  input  logic          id_memread,
  input  logic          id_memwrite,
  input  logic          id_hlt,
  input  logic          exmem_regwrite,
  input  logic [RW-1:0] exmem_rd,
  input  logic [DW-1:0] exmem_result,
  input  logic          memwb_regwrite,
  input  logic [RW-1:0] memwb_rd,
  input  logic [DW-1:0] memwb_result,
  output logic          ex_valid,
  output logic          ex_regwrite,
  output logic          ex_memread,
  output logic          ex_memwrite,
  output logic          ex_hlt,
  output logic [3:0]    ex_opcode,
  output logic [RW-1:0] ex_rd_addr,
  output logic [RW-1:0] ex_rs_addr,
  output logic [RW-1:0] ex_rt_addr,
  output logic [DW-1:0] ex_imm,
  output logic [DW-1:0] ex_rs_val,
  output logic [DW-1:0] ex_rt_val,
  output logic          ex_red_sel,
  output logic [1:0]    fwd_rs_sel,
  output logic [1:0]    fwd_rt_sel
);

  logic [DW-1:0] rs_data_p1;
  logic [DW-1:0] rt_data_p1;

  // ---- ID -> EX boundary: flush beats stall beats load ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid    <= 1'b0;
      ex_regwrite <= 1'b0;
      ex_memread  <= 1'b0;
      ex_memwrite <= 1'b0;
      ex_hlt      <= 1'b0;
      ex_opcode   <= '0;
      ex_rd_addr  <= '0;
      ex_rs_addr  <= '0;
      ex_rt_addr  <= '0;
      ex_imm      <= '0;
      rs_data_p1  <= '0;
      rt_data_p1  <= '0;
    end else if (flush) begin
      ex_valid    <= 1'b0;
      ex_regwrite <= 1'b0;
      ex_memread  <= 1'b0;
      ex_memwrite <= 1'b0;
      ex_hlt      <= 1'b0;
      ex_opcode   <= '0;
      ex_rd_addr  <= '0;
      ex_rs_addr  <= '0;
      ex_rt_addr  <= '0;
      ex_imm      <= '0;
      rs_data_p1  <= '0;
      rt_data_p1  <= '0;
    end else if (!stall) begin
      // Side-effecting control is squashed for an empty decode slot.
      ex_valid    <= id_valid;
      ex_regwrite <= id_valid & id_regwrite;
      ex_memread  <= id_valid & id_memread;
      ex_memwrite <= id_valid & id_memwrite;
      ex_hlt      <= id_valid & id_hlt;
      ex_opcode   <= id_opcode;
      ex_rd_addr  <= id_rd_addr;
      ex_rs_addr  <= id_rs_addr;
      ex_rt_addr  <= id_rt_addr;
      ex_imm      <= id_imm;
      rs_data_p1  <= id_rs_data;
      rt_data_p1  <= id_rt_data;
    end
  end

  assign ex_red_sel = ex_valid & (ex_opcode == OP_RED);

  // ---- EX operand forwarding (combinational, no added latency) ----
  fwd_mux #(.DW(DW), .RW(RW)) u_fwd_rs (
    .src_addr       (ex_rs_addr),
    .reg_data       (rs_data_p1),
    .exmem_regwrite (exmem_regwrite),
    .exmem_rd       (exmem_rd),
    .exmem_result   (exmem_result),
    .memwb_regwrite (memwb_regwrite),
    .memwb_rd       (memwb_rd),
    .memwb_result   (memwb_result),
    .val            (ex_rs_val),
    .sel            (fwd_rs_sel)
  );

  fwd_mux #(.DW(DW), .RW(RW)) u_fwd_rt (
    .src_addr       (ex_rt_addr),
    .reg_data       (rt_data_p1),
    .exmem_regwrite (exmem_regwrite),
    .exmem_rd       (exmem_rd),
    .exmem_result   (exmem_result),
    .memwb_regwrite (memwb_regwrite),
    .memwb_rd       (memwb_rd),
    .memwb_result   (memwb_result),
    .val            (ex_rt_val),
    .sel            (fwd_rt_sel)
  );

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed vector table, hand sequences for
// stall/flush/reset, and a randomized run against a slot-level model.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, flush;
  logic        id_valid;
  logic [3:0]  id_opcode;
  logic [3:0]  id_rs_addr, id_rt_addr, id_rd_addr;
  logic [15:0] id_rs_data, id_rt_data, id_imm;
  logic        id_regwrite, id_memread, id_memwrite, id_hlt;
  logic        exmem_regwrite;
  logic [3:0]  exmem_rd;
  logic [15:0] exmem_result;
  logic        memwb_regwrite;
  logic [3:0]  memwb_rd;
  logic [15:0] memwb_result;
  logic        ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_hlt;
  logic [3:0]  ex_opcode, ex_rd_addr, ex_rs_addr, ex_rt_addr;
  logic [15:0] ex_imm, ex_rs_val, ex_rt_val;
  logic        ex_red_sel;
  logic [1:0]  fwd_rs_sel, fwd_rt_sel;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.DW(16), .RW(4)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr), .id_rd_addr(id_rd_addr),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_regwrite(id_regwrite), .id_memread(id_memread),
    .id_memwrite(id_memwrite), .id_hlt(id_hlt),
    .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .ex_valid(ex_valid), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .ex_memwrite(ex_memwrite), .ex_hlt(ex_hlt), .ex_opcode(ex_opcode),
    .ex_rd_addr(ex_rd_addr), .ex_rs_addr(ex_rs_addr), .ex_rt_addr(ex_rt_addr),
    .ex_imm(ex_imm), .ex_rs_val(ex_rs_val), .ex_rt_val(ex_rt_val),
    .ex_red_sel(ex_red_sel), .fwd_rs_sel(fwd_rs_sel), .fwd_rt_sel(fwd_rt_sel)
  );

  // Reference model: the instruction slot currently sitting in EX.
  typedef struct {
    logic        valid, rw, mr, mw, hlt;
    logic [3:0]  op, rs, rt, rd;
    logic [15:0] rsd, rtd, imm;
  } slot_t;
  slot_t m;

  typedef struct {
    logic        stall, flush, valid;
    logic [3:0]  op, rs, rt, rd;
    logic [15:0] rsd, rtd, imm;
    logic        rw, mw;
    logic        xrw; logic [3:0] xrd; logic [15:0] xres;
    logic        wrw; logic [3:0] wrd; logic [15:0] wres;
    logic        e_valid, e_red, e_rw, e_mw;
    logic [15:0] e_rs, e_rt;
    logic [1:0]  e_rss, e_rts;
  } vec_t;
  vec_t tbl [9];

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic clear_slot();
    m.valid = 1'b0; m.rw = 1'b0; m.mr = 1'b0; m.mw = 1'b0; m.hlt = 1'b0;
    m.op = '0; m.rs = '0; m.rt = '0; m.rd = '0;
    m.rsd = '0; m.rtd = '0; m.imm = '0;
  endtask

  task automatic idle_inputs();
    stall = 0; flush = 0; id_valid = 0; id_opcode = 0;
    id_rs_addr = 0; id_rt_addr = 0; id_rd_addr = 0;
    id_rs_data = 0; id_rt_data = 0; id_imm = 0;
    id_regwrite = 0; id_memread = 0; id_memwrite = 0; id_hlt = 0;
    exmem_regwrite = 0; exmem_rd = 0; exmem_result = 0;
    memwb_regwrite = 0; memwb_rd = 0; memwb_result = 0;
  endtask

  // Advance one clock, updating the model with the inputs seen at the edge.
  task automatic step();
    @(posedge clk);
    if (flush) clear_slot();
    else if (!stall) begin
      m.valid = id_valid;
      m.rw = id_valid && id_regwrite;
      m.mr = id_valid && id_memread;
      m.mw = id_valid && id_memwrite;
      m.hlt = id_valid && id_hlt;
      m.op = id_opcode; m.rs = id_rs_addr; m.rt = id_rt_addr; m.rd = id_rd_addr;
      m.rsd = id_rs_data; m.rtd = id_rt_data; m.imm = id_imm;
    end
    #1;
  endtask

  // Newest producer wins; writes to R0 are never forwarded.
  task automatic expect_operand(input logic [3:0] a, input logic [15:0] regval,
                                output logic [15:0] v, output logic [1:0] s);
    if (exmem_regwrite && exmem_rd != 0 && exmem_rd == a) begin
      v = exmem_result; s = 2'b10;
    end else if (memwb_regwrite && memwb_rd != 0 && memwb_rd == a) begin
      v = memwb_result; s = 2'b01;
    end else begin
      v = regval; s = 2'b00;
    end
  endtask

  task automatic model_check(input string tag);
    logic [15:0] rv, tv;
    logic [1:0]  rsel, tsel;
    expect_operand(m.rs, m.rsd, rv, rsel);
    expect_operand(m.rt, m.rtd, tv, tsel);
    chk({tag, ".valid"},    16'(ex_valid),    16'(m.valid));
    chk({tag, ".regwrite"}, 16'(ex_regwrite), 16'(m.rw));
    chk({tag, ".memread"},  16'(ex_memread),  16'(m.mr));
    chk({tag, ".memwrite"}, 16'(ex_memwrite), 16'(m.mw));
    chk({tag, ".hlt"},      16'(ex_hlt),      16'(m.hlt));
    chk({tag, ".opcode"},   16'(ex_opcode),   16'(m.op));
    chk({tag, ".rd"},       16'(ex_rd_addr),  16'(m.rd));
    chk({tag, ".imm"},      ex_imm,           m.imm);
    chk({tag, ".rs_val"},   ex_rs_val,        rv);
    chk({tag, ".rt_val"},   ex_rt_val,        tv);
    chk({tag, ".rs_sel"},   16'(fwd_rs_sel),  16'(rsel));
    chk({tag, ".rt_sel"},   16'(fwd_rt_sel),  16'(tsel));
    chk({tag, ".red_sel"},  16'(ex_red_sel),  16'(m.valid && m.op == 4'b0011));
  endtask

  task automatic apply_vec(input vec_t v, input int idx);
    string t;
    stall = v.stall; flush = v.flush; id_valid = v.valid; id_opcode = v.op;
    id_rs_addr = v.rs; id_rt_addr = v.rt; id_rd_addr = v.rd;
    id_rs_data = v.rsd; id_rt_data = v.rtd; id_imm = v.imm;
    id_regwrite = v.rw; id_memwrite = v.mw; id_memread = 0; id_hlt = 0;
    exmem_regwrite = v.xrw; exmem_rd = v.xrd; exmem_result = v.xres;
    memwb_regwrite = v.wrw; memwb_rd = v.wrd; memwb_result = v.wres;
    step();
    t = $sformatf("vec%0d", idx);
    chk({t, ".valid"},    16'(ex_valid),    16'(v.e_valid));
    chk({t, ".red_sel"},  16'(ex_red_sel),  16'(v.e_red));
    chk({t, ".regwrite"}, 16'(ex_regwrite), 16'(v.e_rw));
    chk({t, ".memwrite"}, 16'(ex_memwrite), 16'(v.e_mw));
    chk({t, ".rs_val"},   ex_rs_val,        v.e_rs);
    chk({t, ".rt_val"},   ex_rt_val,        v.e_rt);
    chk({t, ".rs_sel"},   16'(fwd_rs_sel),  16'(v.e_rss));
    chk({t, ".rt_sel"},   16'(fwd_rt_sel),  16'(v.e_rts));
  endtask

  initial begin
    // stall flush valid op rs rt rd rsd rtd imm rw mw | exmem | memwb | expected
    tbl[0] = '{1'b0,1'b0,1'b1,4'h3,4'd1,4'd2,4'd3,16'h7F80,16'h0181,16'h0000,1'b1,1'b0,
               1'b0,4'd0,16'h0000, 1'b0,4'd0,16'h0000,
               1'b1,1'b1,1'b1,1'b0,16'h7F80,16'h0181,2'b00,2'b00};
    tbl[1] = '{1'b0,1'b0,1'b1,4'h0,4'd5,4'd6,4'd7,16'h1111,16'h2222,16'h0000,1'b1,1'b0,
               1'b1,4'd5,16'h1234, 1'b1,4'd5,16'hABCD,
               1'b1,1'b0,1'b1,1'b0,16'h1234,16'h2222,2'b10,2'b00};
    tbl[2] = '{1'b1,1'b0,1'b1,4'h3,4'd9,4'd10,4'd11,16'h0BAD,16'h0BAD,16'h0000,1'b1,1'b1,
               1'b0,4'd5,16'h1234, 1'b1,4'd5,16'hABCD,
               1'b1,1'b0,1'b1,1'b0,16'hABCD,16'h2222,2'b01,2'b00};
    tbl[3] = '{1'b0,1'b0,1'b1,4'h0,4'd1,4'd0,4'd2,16'h0055,16'h0000,16'h0000,1'b1,1'b0,
               1'b1,4'd0,16'hFFFF, 1'b1,4'd0,16'hEEEE,
               1'b1,1'b0,1'b1,1'b0,16'h0055,16'h0000,2'b00,2'b00};
    tbl[4] = '{1'b0,1'b0,1'b0,4'h3,4'd3,4'd4,4'd5,16'h0101,16'h0202,16'h0000,1'b1,1'b1,
               1'b0,4'd0,16'h0000, 1'b0,4'd0,16'h0000,
               1'b0,1'b0,1'b0,1'b0,16'h0101,16'h0202,2'b00,2'b00};
    tbl[5] = '{1'b0,1'b0,1'b1,4'h2,4'd3,4'd4,4'd5,16'h0001,16'h0002,16'h0000,1'b0,1'b1,
               1'b1,4'd3,16'h00C3, 1'b1,4'd4,16'h5A5A,
               1'b1,1'b0,1'b0,1'b1,16'h00C3,16'h5A5A,2'b10,2'b01};
    tbl[6] = '{1'b1,1'b1,1'b1,4'h3,4'd5,4'd6,4'd7,16'h1111,16'h2222,16'h0000,1'b1,1'b1,
               1'b1,4'd5,16'h1234, 1'b1,4'd6,16'hABCD,
               1'b0,1'b0,1'b0,1'b0,16'h0000,16'h0000,2'b00,2'b00};
    tbl[7] = '{1'b0,1'b1,1'b1,4'h0,4'd1,4'd2,4'd3,16'h3333,16'h4444,16'h0000,1'b1,1'b1,
               1'b0,4'd0,16'h0000, 1'b0,4'd0,16'h0000,
               1'b0,1'b0,1'b0,1'b0,16'h0000,16'h0000,2'b00,2'b00};
    tbl[8] = '{1'b0,1'b0,1'b1,4'h3,4'd7,4'd7,4'd1,16'h0F0F,16'h0F0F,16'h0000,1'b1,1'b0,
               1'b0,4'd7,16'h0001, 1'b1,4'd7,16'hBEEF,
               1'b1,1'b1,1'b1,1'b0,16'hBEEF,16'hBEEF,2'b01,2'b01};

    idle_inputs();
    clear_slot();
    rst = 1'b1;
    #12;
    chk("rst.valid",    16'(ex_valid),    16'h0);
    chk("rst.regwrite", 16'(ex_regwrite), 16'h0);
    chk("rst.rs_val",   ex_rs_val,        16'h0);
    chk("rst.rt_sel",   16'(fwd_rt_sel),  16'h0);
    rst = 1'b0;
    step();
    model_check("post_rst");

    for (int i = 0; i < 9; i++) apply_vec(tbl[i], i);

    // Stall holds an ADD for three cycles while decode keeps changing.
    idle_inputs();
    id_valid = 1; id_opcode = 4'h0; id_rs_addr = 4'd1; id_rt_addr = 4'd2; id_rd_addr = 4'd3;
    id_rs_data = 16'hAAAA; id_rt_data = 16'h5555; id_imm = 16'h0042; id_regwrite = 1;
    step();
    stall = 1;
    for (int c = 0; c < 3; c++) begin
      id_opcode = 4'($urandom); id_rd_addr = 4'($urandom); id_rs_data = 16'($urandom);
      id_imm = 16'($urandom); id_memwrite = 1;
      step();
      chk("hold.opcode", 16'(ex_opcode),  16'h0000);
      chk("hold.rd",     16'(ex_rd_addr), 16'h0003);
      chk("hold.rs_val", ex_rs_val,       16'hAAAA);
      chk("hold.imm",    ex_imm,          16'h0042);
      chk("hold.memwr",  16'(ex_memwrite), 16'h0);
    end
    flush = 1;
    step();
    chk("sf.valid",    16'(ex_valid),    16'h0);
    chk("sf.regwrite", 16'(ex_regwrite), 16'h0);
    chk("sf.memwrite", 16'(ex_memwrite), 16'h0);

    // Asynchronous reset mid-stall, then release into an idle decode.
    idle_inputs();
    id_valid = 1; id_opcode = 4'h3; id_rs_addr = 4'd3; id_rt_addr = 4'd4;
    id_rs_data = 16'h1357; id_rt_data = 16'h2468; id_regwrite = 1; id_hlt = 1;
    step();
    model_check("pre_arst");
    stall = 1; exmem_regwrite = 1; exmem_rd = 4'd3; exmem_result = 16'hFFFF;
    #2 rst = 1'b1;
    #1;
    clear_slot();
    chk("arst.valid",   16'(ex_valid),    16'h0);
    chk("arst.red_sel", 16'(ex_red_sel),  16'h0);
    chk("arst.hlt",     16'(ex_hlt),      16'h0);
    chk("arst.rs_val",  ex_rs_val,        16'h0);
    chk("arst.rs_sel",  16'(fwd_rs_sel),  16'h0);
    chk("arst.rt_val",  ex_rt_val,        16'h0);
    #1;
    idle_inputs();
    rst = 1'b0;
    step();
    model_check("arst_rel");

    // Randomized traffic with narrow address space to provoke hazards.
    for (int n = 0; n < 400; n++) begin
      stall = ($urandom_range(0, 4) == 0);
      flush = ($urandom_range(0, 7) == 0);
      id_valid = ($urandom_range(0, 3) != 0);
      id_opcode = 4'($urandom);
      id_rs_addr = 4'($urandom_range(0, 7));
      id_rt_addr = 4'($urandom_range(0, 7));
      id_rd_addr = 4'($urandom);
      id_rs_data = 16'($urandom); id_rt_data = 16'($urandom); id_imm = 16'($urandom);
      id_regwrite = 1'($urandom); id_memread = 1'($urandom);
      id_memwrite = 1'($urandom); id_hlt = 1'($urandom);
      exmem_regwrite = 1'($urandom); exmem_rd = 4'($urandom_range(0, 7));
      exmem_result = 16'($urandom);
      memwb_regwrite = 1'($urandom); memwb_rd = 4'($urandom_range(0, 7));
      memwb_result = 16'($urandom);
      step();
      model_check($sformatf("rnd%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
